// File: rtl/uart_tx_ctrl_if.sv
// Bus bundle between the control register and the UART transmit engine.
// The register side (master) supplies the control word and the byte to send.
// The engine side (slave) returns the serial line, the busy flag and the
// SEND-clearing write-back.
interface uart_tx_ctrl_if #(
    parameter int N = 32
);
    logic [N-1:0] control_i;
    logic [7:0]   data_i;
    logic         tx_o;
    logic         busy_o;
    logic         ctrl_wr_o;
    logic [N-1:0] ctrl_o;

    modport master (
        output control_i,
        output data_i,
        input  tx_o,
        input  busy_o,
        input  ctrl_wr_o,
        input  ctrl_o
    );

    modport slave (
        input  control_i,
        input  data_i,
        output tx_o,
        output busy_o,
        output ctrl_wr_o,
        output ctrl_o
    );
endinterface

// File: rtl/uart_tx_ctrl.sv
// UART 8N1 transmit engine driven by the SEND bit of a control register.
// When SEND is seen in IDLE, the engine latches the byte and sends the frame
// start, 8 data bits LSB first, then stop. It then spends one DONE cycle
// writing the control word back with SEND cleared, which acknowledges the
// request to the CPU.
module uart_tx_ctrl #(
    parameter int N            = 32,
    parameter int CLKS_PER_BIT = 10417
) (
    input logic           clk_i,
    input logic           rst_i,
    uart_tx_ctrl_if.slave bus
);
    localparam int            BW        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        DONE
    } state_t;

    state_t        state;
    logic [BW-1:0] baud_cnt;
    logic [2:0]    bit_cnt;
    logic [7:0]    shift_q;
    logic          tx_q;
    logic          busy_q;
    logic          wr_q;
    logic          bit_end;

    assign bit_end       = (baud_cnt == BAUD_LAST);
    assign bus.tx_o      = tx_q;
    assign bus.busy_o    = busy_q;
    assign bus.ctrl_wr_o = wr_q;
    assign bus.ctrl_o    = {bus.control_i[N-1:1], 1'b0};

    // Frame sequencer: the outputs are registered, so each output takes the value of the state being entered.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            shift_q  <= '0;
            tx_q     <= 1'b1;
            busy_q   <= 1'b0;
            wr_q     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    tx_q   <= 1'b1;
                    busy_q <= 1'b0;
                    wr_q   <= 1'b0;
                    if (bus.control_i[0]) begin
                        shift_q  <= bus.data_i;
                        baud_cnt <= '0;
                        bit_cnt  <= '0;
                        tx_q     <= 1'b0;
                        busy_q   <= 1'b1;
                        state    <= START;
                    end
                end
                START: begin
                    if (bit_end) begin
                        baud_cnt <= '0;
                        tx_q     <= shift_q[0];
                        state    <= DATA;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        baud_cnt <= '0;
                        shift_q  <= shift_q >> 1;
                        bit_cnt  <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            tx_q  <= 1'b1;
                            state <= STOP;
                        end else begin
                            tx_q <= shift_q[1];
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (bit_end) begin
                        baud_cnt <= '0;
                        tx_q     <= 1'b1;
                        wr_q     <= 1'b1;
                        state    <= DONE;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                DONE: begin
                    baud_cnt <= '0;
                    tx_q     <= 1'b1;
                    busy_q   <= 1'b0;
                    wr_q     <= 1'b0;
                    state    <= IDLE;
                end
                default: begin
                    baud_cnt <= '0;
                    tx_q     <= 1'b1;
                    busy_q   <= 1'b0;
                    wr_q     <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Bench for uart_tx_ctrl with CLKS_PER_BIT=4. It uses a cycle-level reference
// model of the frame timeline and a model of the control register, in which a
// CPU write (WR1) has priority over the engine's write-back (WR2).
module tb_uart_tx_ctrl;
    localparam int N   = 32;
    localparam int CPB = 4;
    localparam int FRAME_END = 10 * CPB + 1;

    logic clk;
    logic rst;

    uart_tx_ctrl_if #(.N(N)) bus ();

    uart_tx_ctrl #(
        .N            (N),
        .CLKS_PER_BIT (CPB)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    int          cyc;
    int          checks;
    int          errors;
    int          base;
    int          rel;
    int          wrPulses;
    logic [31:0] regv;
    logic [31:0] lastWrCtrl;
    bit          mActive;
    int          mStart;
    logic [7:0]  mByte;
    int          a5Seq [10];

    // Free-running clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare one observed value against its expectation and tally the result.
    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Expected line level at position k (0-based) within the 10-bit frame.
    function automatic logic frameBit(input int k, input logic [7:0] b);
        int idx;
        idx = k / CPB;
        if (idx == 0) return 1'b0;
        if (idx == 9) return 1'b1;
        return b[idx-1];
    endfunction

    // Run one clock cycle: drive the inputs, check the outputs against the model,
    // then advance the model and the register model.
    task automatic applyStimulus(input logic r, input logic [7:0] d, input logic w, input logic [31:0] v);
        logic        expTx;
        logic        expBusy;
        logic        expWr;
        int          offs;
        logic [31:0] regOld;
        rst           = r;
        bus.control_i = regv;
        bus.data_i    = d;
        #1;
        expTx   = 1'b1;
        expBusy = 1'b0;
        expWr   = 1'b0;
        offs    = cyc - mStart;
        if (mActive) begin
            expBusy = 1'b1;
            if (offs < FRAME_END) expTx = frameBit(offs - 1, mByte);
            else expWr = 1'b1;
        end
        checkOutput("tx", bus.tx_o, expTx);
        checkOutput("busy", bus.busy_o, expBusy);
        checkOutput("ctrl_wr", bus.ctrl_wr_o, expWr);
        checkOutput("ctrl_o", bus.ctrl_o, {regv[31:1], 1'b0});
        if (bus.ctrl_wr_o === 1'b1) lastWrCtrl = bus.ctrl_o;
        regOld = regv;
        if (r) regv = '0;
        else if (w) regv = v;
        else if (expWr) regv = {regv[31:1], 1'b0};
        if (r) mActive = 1'b0;
        else if (mActive && offs == FRAME_END) mActive = 1'b0;
        else if (!mActive && regOld[0]) begin
            mActive = 1'b1;
            mStart  = cyc;
            mByte   = d;
        end
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    // Directed scenarios followed by a randomized phase.
    initial begin
        a5Seq = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 1};
        checks = 0; errors = 0; cyc = 0; wrPulses = 0;
        regv = '0; mActive = 1'b0; mStart = 0; mByte = '0;
        lastWrCtrl = 32'hDEAD_BEEF;
        rst = 1'b1; bus.control_i = '0; bus.data_i = '0;
        @(negedge clk);

        // Reset held for three cycles, then released.
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 8'h00, 1'b0, 32'h0);
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 8'h00, 1'b0, 32'h0);
        checkOutput("post_reset_tx", bus.tx_o, 1);
        checkOutput("post_reset_busy", bus.busy_o, 0);
        checkOutput("post_reset_wr", bus.ctrl_wr_o, 0);

        // Single frame with byte A5.
        applyStimulus(1'b0, 8'hA5, 1'b1, 32'h1);
        base = cyc;
        for (int i = 0; i < 44; i++) begin
            applyStimulus(1'b0, 8'hA5, 1'b0, 32'h0);
            rel = cyc - base;
            if (rel >= 1 && rel <= 40 && ((rel - 1) % CPB) == 1)
                checkOutput($sformatf("a5_bit%0d", (rel - 1) / CPB), bus.tx_o, a5Seq[(rel - 1) / CPB]);
            if (rel == 41) checkOutput("a5_wr_done", bus.ctrl_wr_o, 1);
            if (rel == 40 || rel == 42) checkOutput("a5_wr_edge", bus.ctrl_wr_o, 0);
            if (rel == 1 || rel == 41) checkOutput("a5_busy_in", bus.busy_o, 1);
            if (rel == 42) checkOutput("a5_busy_out", bus.busy_o, 0);
        end
        checkOutput("a5_ctrl_o_done", lastWrCtrl, 32'h0);

        // Upper control bits pass through the write-back.
        lastWrCtrl = 32'hDEAD_BEEF;
        applyStimulus(1'b0, 8'h5C, 1'b1, 32'hF0F0_0003);
        for (int i = 0; i < 44; i++) applyStimulus(1'b0, 8'($urandom), 1'b0, 32'h0);
        checkOutput("field_preserve", lastWrCtrl, 32'hF0F0_0002);

        // Back-to-back: CPU rewrites SEND=1 during DONE.
        applyStimulus(1'b0, 8'h3C, 1'b1, 32'h1);
        base = cyc;
        for (int i = 0; i < 90; i++) begin
            rel = cyc - base;
            applyStimulus(1'b0, (rel < 42) ? 8'h3C : 8'hC3, rel == 41, 32'h1);
            rel = cyc - base;
            if (rel == 42) checkOutput("b2b_gap_tx", bus.tx_o, 1);
            if (rel == 42) checkOutput("b2b_gap_busy", bus.busy_o, 0);
            if (rel == 43) checkOutput("b2b_start_tx", bus.tx_o, 0);
            if (rel == 43) checkOutput("b2b_start_busy", bus.busy_o, 1);
            if (rel == 85) checkOutput("b2b_no_third", bus.busy_o, 0);
        end

        // Data input changes mid-frame are ignored.
        applyStimulus(1'b0, 8'hFF, 1'b1, 32'h1);
        base = cyc;
        for (int i = 0; i < 44; i++) begin
            rel = cyc - base;
            applyStimulus(1'b0, (rel >= 10) ? 8'h00 : 8'hFF, 1'b0, 32'h0);
            rel = cyc - base;
            if (rel >= 5 && rel <= 36 && ((rel - 1) % CPB) == 1)
                checkOutput("ff_data_bit", bus.tx_o, 1);
        end

        // Mid-frame reset truncates the frame without a write-back.
        applyStimulus(1'b0, 8'h0F, 1'b1, 32'h1);
        base = cyc;
        for (int i = 0; i < 50; i++) begin
            rel = cyc - base;
            applyStimulus(rel == 20, 8'h0F, 1'b0, 32'h0);
            rel = cyc - base;
            if (rel == 21) checkOutput("rst_mid_tx", bus.tx_o, 1);
            if (rel == 21) checkOutput("rst_mid_busy", bus.busy_o, 0);
            if (bus.ctrl_wr_o === 1'b1) wrPulses++;
        end
        checkOutput("rst_mid_no_wr", wrPulses, 0);
        lastWrCtrl = 32'hDEAD_BEEF;
        applyStimulus(1'b0, 8'h96, 1'b1, 32'h1);
        for (int i = 0; i < 44; i++) applyStimulus(1'b0, 8'h96, 1'b0, 32'h0);
        checkOutput("after_rst_frame_wr", lastWrCtrl, 32'h0);

        // Randomized traffic: random bytes, sporadic CPU writes and rare resets.
        for (int i = 0; i < 600; i++) begin
            applyStimulus($urandom_range(0, 299) == 0, 8'($urandom),
                          $urandom_range(0, 15) == 0, $urandom);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
